// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key-event decoder: prefix bytes, the
// bytes that never form an event, and the decoder state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_E0 = 8'hE0;
    localparam logic [7:0] PS2_F0 = 8'hF0;
    localparam int         EV_W   = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    // Keyboard status/ack bytes: they end any pending prefix but carry no key.
    function automatic logic ps2_is_discard(input logic [7:0] b);
        case (b)
            8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFC, 8'hFF: ps2_is_discard = 1'b1;
            default:                                         ps2_is_discard = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Event FIFO: push/full on the write side, valid/ready on the read side.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    output logic         full_o,
    output logic         pop_valid_o,
    input  logic         pop_ready_i,
    output logic [W-1:0] pop_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_C  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          pop_w;
    logic          push_w;

    assign full_o      = (count_q == FULL_C);
    assign pop_valid_o = (count_q != '0);
    assign pop_w       = pop_valid_o && pop_ready_i;
    assign push_w      = push_i && (!full_o || pop_w);
    // Empty FIFO presents zeros so the head fields are defined out of reset.
    assign pop_data_o  = pop_valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (push_w) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_w) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop_w) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({push_w, pop_w})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scan-code set 2 decoder: folds E0/F0 prefixes into {code, ext, break}
// events queued in a FIFO. Define PS2_TYPEMATIC_FILTER_EN to drop typematic repeats.
module ps2_key_event
    import ps2_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    input  logic        kflag,
    output logic        ev_valid,
    input  logic        ev_ready,
    output logic [7:0]  ev_code,
    output logic        ev_ext,
    output logic        ev_break,
    output logic        ovf,
    output logic [1:0]  dbg_state
);

    ps2_state_e      state_q;
    logic            dec_valid_q;
    logic [EV_W-1:0] dec_q;
    logic            ovf_q;
    logic [7:0]      byte_w;
    logic            ext_w;
    logic            brk_w;
    logic            suppress_w;
    logic            fifo_full;
    logic [EV_W-1:0] head_w;
    logic            unused_hist;

    assign byte_w      = keycode[7:0];
    assign unused_hist = ^keycode[15:8];
    assign ext_w       = (state_q == ST_EXT) || (state_q == ST_BRK ? 1'b0 : state_q == ST_EXT_BRK);
    assign brk_w       = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic       held_valid_q;
    logic [8:0] held_q;
    logic       is_data_w;

    assign is_data_w  = (byte_w != PS2_E0) && (byte_w != PS2_F0) && !ps2_is_discard(byte_w);
    assign suppress_w = !brk_w && held_valid_q && (held_q == {ext_w, byte_w});

    always_ff @(posedge clk) begin
        if (rst) begin
            held_valid_q <= 1'b0;
            held_q       <= '0;
        end else if (kflag && is_data_w) begin
            if (!brk_w) begin
                held_valid_q <= 1'b1;
                held_q       <= {ext_w, byte_w};
            end else if (held_valid_q && (held_q == {ext_w, byte_w})) begin
                held_valid_q <= 1'b0;
            end
        end
    end
`else
    assign suppress_w = 1'b0;
`endif

    // Decoder FSM; the decoded event is registered and pushed the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            dec_valid_q <= 1'b0;
            dec_q       <= '0;
        end else begin
            dec_valid_q <= 1'b0;
            if (kflag) begin
                if (byte_w == PS2_E0) begin
                    state_q <= ST_EXT;
                end else if (byte_w == PS2_F0) begin
                    if (state_q == ST_IDLE) begin
                        state_q <= ST_BRK;
                    end else if (state_q == ST_EXT) begin
                        state_q <= ST_EXT_BRK;
                    end
                end else begin
                    state_q <= ST_IDLE;
                    if (!ps2_is_discard(byte_w) && !suppress_w) begin
                        dec_valid_q <= 1'b1;
                        dec_q       <= {ext_w, brk_w, byte_w};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (dec_valid_q && fifo_full && !(ev_valid && ev_ready)) begin
            ovf_q <= 1'b1;
        end
    end

    key_event_fifo #(
        .DEPTH (DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (dec_valid_q),
        .push_data_i (dec_q),
        .full_o      (fifo_full),
        .pop_valid_o (ev_valid),
        .pop_ready_i (ev_ready),
        .pop_data_o  (head_w)
    );

    assign ev_ext    = head_w[9];
    assign ev_break  = head_w[8];
    assign ev_code   = head_w[7:0];
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Directed bench for ps2_key_event: a table of byte sequences with expected
// events, plus hand-written latency, overflow, full push/pop and reset sequences.
module tb_ps2_key_event;

    localparam int DEPTH = 4;
    localparam int NV    = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] keycode;
    logic        kflag;
    logic        ev_valid;
    logic        ev_ready;
    logic [7:0]  ev_code;
    logic        ev_ext;
    logic        ev_break;
    logic        ovf;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        int         n;
        logic [7:0] b [4];
        logic       exp_ev;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs [NV];

    always #5 clk = ~clk;

    ps2_key_event #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .keycode   (keycode),
        .kflag     (kflag),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_code   (ev_code),
        .ev_ext    (ev_ext),
        .ev_break  (ev_break),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        keycode = {keycode[7:0], b};
        kflag   = 1'b1;
        @(negedge clk);
        kflag   = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        kflag    = 1'b0;
        ev_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
    endtask

    task automatic pop_expect(input string name, input logic [9:0] exp);
        check({name, " valid"}, 32'(ev_valid), 32'(1));
        check({name, " event"}, 32'({ev_ext, ev_break, ev_code}), 32'(exp));
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic check_quiet(input string name);
        check({name, " ev_valid"}, 32'(ev_valid), 32'(0));
        check({name, " ev_code"}, 32'(ev_code), 32'(0));
        check({name, " ext/break"}, 32'({ev_ext, ev_break}), 32'(0));
        check({name, " ovf"}, 32'(ovf), 32'(0));
        check({name, " state"}, 32'(dbg_state), 32'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected $finish");
        $fatal(1);
    end

    initial begin
        int n_ev;
        logic [7:0] fseq [6];

        vecs[0] = '{1, '{8'h1C, 8'h00, 8'h00, 8'h00}, 1'b1, {2'b00, 8'h1C}};
        vecs[1] = '{2, '{8'hF0, 8'h1C, 8'h00, 8'h00}, 1'b1, {2'b01, 8'h1C}};
        vecs[2] = '{3, '{8'hE0, 8'hF0, 8'h75, 8'h00}, 1'b1, {2'b11, 8'h75}};
        vecs[3] = '{2, '{8'hE0, 8'h6B, 8'h00, 8'h00}, 1'b1, {2'b10, 8'h6B}};
        vecs[4] = '{1, '{8'hFA, 8'h00, 8'h00, 8'h00}, 1'b0, 10'h000};
        vecs[5] = '{1, '{8'hAA, 8'h00, 8'h00, 8'h00}, 1'b0, 10'h000};
        vecs[6] = '{4, '{8'hE0, 8'hF0, 8'hF0, 8'h74}, 1'b1, {2'b11, 8'h74}};
        vecs[7] = '{3, '{8'hF0, 8'hE0, 8'h5A, 8'h00}, 1'b1, {2'b10, 8'h5A}};
        vecs[8] = '{3, '{8'hE0, 8'hFF, 8'h29, 8'h00}, 1'b1, {2'b00, 8'h29}};
        vecs[9] = '{3, '{8'hF0, 8'hF0, 8'h29, 8'h00}, 1'b1, {2'b01, 8'h29}};

        rst = 1'b1; kflag = 1'b0; ev_ready = 1'b0; keycode = 16'h0000;
        repeat (3) @(negedge clk);
        check_quiet("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after reset");

        // Latency: ev_valid rises two cycles after kflag.
        keycode = {keycode[7:0], 8'h1C};
        kflag   = 1'b1;
        @(negedge clk);
        kflag   = 1'b0;
        check("latency +1 ev_valid", 32'(ev_valid), 32'(0));
        @(negedge clk);
        check("latency +2 ev_valid", 32'(ev_valid), 32'(1));
        pop_expect("latency 1C", {2'b00, 8'h1C});
        check("latency empty", 32'(ev_valid), 32'(0));

        // Table of byte sequences.
        do_reset();
        for (int i = 0; i < NV; i++) begin
            for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
            idle(2);
            check($sformatf("vec%0d ev_valid", i), 32'(ev_valid), 32'(vecs[i].exp_ev));
            if (vecs[i].exp_ev) begin
                pop_expect($sformatf("vec%0d", i), vecs[i].exp);
                check($sformatf("vec%0d single event", i), 32'(ev_valid), 32'(0));
            end
            check($sformatf("vec%0d state", i), 32'(dbg_state), 32'(0));
        end

        // Typematic repeat sequence, popped as events appear.
        do_reset();
        fseq = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
        exp_q.delete();
`ifdef PS2_TYPEMATIC_FILTER_EN
        exp_q.push_back({2'b00, 8'h1C});
        exp_q.push_back({2'b01, 8'h1C});
        exp_q.push_back({2'b00, 8'h1C});
`else
        exp_q.push_back({2'b00, 8'h1C});
        exp_q.push_back({2'b00, 8'h1C});
        exp_q.push_back({2'b00, 8'h1C});
        exp_q.push_back({2'b01, 8'h1C});
        exp_q.push_back({2'b00, 8'h1C});
`endif
        n_ev = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(fseq[i]);
            idle(1);
            if (ev_valid) begin
                n_ev++;
                if (exp_q.size() == 0) check($sformatf("typematic extra event %0d", i), 32'(ev_valid), 32'(0));
                else pop_expect($sformatf("typematic byte%0d", i), exp_q.pop_front());
            end
        end
        check("typematic missing events", 32'(exp_q.size()), 32'(0));
`ifdef PS2_TYPEMATIC_FILTER_EN
        check("typematic event count", 32'(n_ev), 32'(3));
`else
        check("typematic event count", 32'(n_ev), 32'(5));
`endif

        // Overflow: fifth event dropped, first four kept in order.
        do_reset();
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        idle(1);
        check("ovf before drop", 32'(ovf), 32'(0));
        send_byte(8'h2C);
        idle(2);
        check("ovf after drop", 32'(ovf), 32'(1));
        exp_q = '{{2'b00, 8'h15}, {2'b00, 8'h1D}, {2'b00, 8'h24}, {2'b00, 8'h2D}};
        for (int i = 0; i < 4; i++) pop_expect($sformatf("ovf drain%0d", i), exp_q.pop_front());
        check("ovf drained empty", 32'(ev_valid), 32'(0));
        check("ovf sticky", 32'(ovf), 32'(1));

        // Full FIFO: push and pop land on the same edge.
        do_reset();
        check("full test ovf cleared", 32'(ovf), 32'(0));
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        idle(1);
        @(negedge clk);
        keycode = {keycode[7:0], 8'h2C};
        kflag   = 1'b1;
        @(negedge clk);
        kflag    = 1'b0;
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
        idle(1);
        check("full push+pop ovf", 32'(ovf), 32'(0));
        exp_q = '{{2'b00, 8'h1D}, {2'b00, 8'h24}, {2'b00, 8'h2D}, {2'b00, 8'h2C}};
        for (int i = 0; i < 4; i++) pop_expect($sformatf("full drain%0d", i), exp_q.pop_front());
        check("full drained empty", 32'(ev_valid), 32'(0));

        // Reset in the middle of a prefix sequence.
        do_reset();
        send_byte(8'hE0);
        check("prefix state EXT", 32'(dbg_state), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("prefix state cleared", 32'(dbg_state), 32'(0));
        send_byte(8'h6B);
        idle(1);
        pop_expect("after reset 6B", {2'b00, 8'h6B});
        send_byte(8'hFA);
        idle(2);
        check("FA no event", 32'(ev_valid), 32'(0));

        // kflag coincident with rst is ignored.
        @(negedge clk);
        rst     = 1'b1;
        kflag   = 1'b1;
        keycode = {keycode[7:0], 8'h1C};
        @(negedge clk);
        rst   = 1'b0;
        kflag = 1'b0;
        idle(3);
        check("kflag in reset ignored", 32'(ev_valid), 32'(0));

        // Reset with a queued event clears the head outputs.
        send_byte(8'h5A);
        idle(1);
        check("queued before reset", 32'(ev_valid), 32'(1));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("reset with queued event");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("after queued reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
